// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio frame buffer: sample formats,
// write/read FSM states and the Q1.15 saturating conversion.
package audio_pkg;

  localparam int unsigned ADC_BITS = 12;
  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [ADC_BITS-1:0]        adc_code_t;

  typedef enum logic {W_FILL, W_WAIT}   wr_state_t;
  typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

  // One entry of the read-side output pipeline (head or skid slot)
  typedef struct packed {
    sample_t data;
    logic    first;
    logic    last;
  } out_word_t;

  // Scale a 13-bit signed offset code to Q1.15, clamping to the 16-bit range
  function automatic sample_t sat_q15(input logic signed [ADC_BITS:0] d);
    logic signed [16:0] w;
    w = 17'(d) <<< 3;
    if (w > 17'sd32767) begin
      sat_q15 = 16'sh7FFF;
    end else if (w < -17'sd32768) begin
      sat_q15 = 16'sh8000;
    end else begin
      sat_q15 = w[15:0];
    end
  endfunction

endpackage

// File: rtl/frame_pingpong_ram.sv
// Two-bank frame store: simple dual-port RAM, one write port and one
// registered read port, addressed as {bank, index}.
module frame_pingpong_ram
  import audio_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
  localparam int unsigned AW = $clog2(FRAME_LEN) + 1
) (
  input  logic          sampling_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sample_t       wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output sample_t       rdata
);

  sample_t mem [0:2*FRAME_LEN-1];

  // No reset on the array or read register so this maps onto block RAM
  always_ff @(posedge sampling_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/audio_frame_buffer.sv
// Converts 12-bit ADC codes to Q1.15, packs them into ping-pong frames and
// streams whole frames out over valid/ready. AUDIO_FRAME_DC_BLOCK_EN swaps the
// fixed mid-code offset for a tracked running mean.
module audio_frame_buffer
  import audio_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
`ifdef AUDIO_FRAME_DC_BLOCK_EN
  parameter int unsigned DCB_SHIFT = 8,
`endif
  parameter int unsigned ADC_MID   = 2048
) (
  input  logic        sampling_clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam int unsigned AW    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  adc_code_t code;
  logic      unused_hi;
  sample_t   conv_data;
  logic      conv_valid;

  assign code      = sample_in[ADC_BITS-1:0];
  assign unused_hi = ^sample_in[15:ADC_BITS];

`ifdef AUDIO_FRAME_DC_BLOCK_EN
  localparam int unsigned ACC_W = ADC_BITS + DCB_SHIFT;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next_c;
  adc_code_t        dc_code;
  adc_code_t        dc_mean;
  logic             dc_valid;
  logic signed [ADC_BITS:0] diff_c;

  // Leaky integrator; acc tracks mean<<DCB_SHIFT and never exceeds ACC_W bits
  assign acc_next_c = acc + ACC_W'(code) - (acc >> DCB_SHIFT);
  assign diff_c     = {1'b0, dc_code} - {1'b0, dc_mean};

  always_ff @(posedge sampling_clk or negedge rst) begin
    if (!rst) begin
      acc        <= ACC_W'(ADC_MID << DCB_SHIFT);
      dc_code    <= '0;
      dc_mean    <= '0;
      dc_valid   <= 1'b0;
      conv_data  <= '0;
      conv_valid <= 1'b0;
    end else begin
      dc_valid   <= sample_valid;
      conv_valid <= dc_valid;
      if (sample_valid) begin
        acc     <= acc_next_c;
        dc_code <= code;
        dc_mean <= acc[ACC_W-1:DCB_SHIFT];
      end
      if (dc_valid) begin
        conv_data <= sat_q15(diff_c);
      end
    end
  end
`else
  logic signed [ADC_BITS:0] diff_c;

  assign diff_c = $signed({1'b0, code}) - $signed((ADC_BITS + 1)'(ADC_MID));

  always_ff @(posedge sampling_clk or negedge rst) begin
    if (!rst) begin
      conv_data  <= '0;
      conv_valid <= 1'b0;
    end else begin
      conv_valid <= sample_valid;
      if (sample_valid) begin
        conv_data <= sat_q15(diff_c);
      end
    end
  end
`endif

  wr_state_t        wstate, wstate_nxt;
  logic             wbank, wbank_nxt;
  logic [IDX_W-1:0] widx, widx_nxt;
  logic [1:0]       full, set_full, clr_full;
  logic [15:0]      fc_nxt;
  logic             ovf_nxt;
  logic             other_free_c;
  logic             ram_we_c;
  logic [AW-1:0]    ram_waddr_c;

  rd_state_t        rstate, rstate_nxt;
  logic             rbank, rbank_nxt;
  logic [IDX_W:0]   fidx, fidx_nxt;
  logic [IDX_W-1:0] fetch_idx_c;
  logic             fetch_bank_c;
  logic             ram_re_c;
  logic             rd_pend, pend_first, pend_last;
  logic             pend_first_nxt, pend_last_nxt;
  sample_t          ram_rdata;
  out_word_t        ram_word_c;
  out_word_t        head, head_nxt, skid, skid_nxt;
  logic             head_valid, head_valid_nxt, skid_valid, skid_valid_nxt;
  logic             pop_c, rd_free_c;
  logic [1:0]       occ_c;

  assign pop_c     = head_valid && out_ready;
  assign rd_free_c = (rstate == R_STREAM) && pop_c && head.last;
  assign occ_c     = 2'(head_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop_c);

  // Write side: fill the current bank, hand it over when the other bank is free
  always_comb begin
    wstate_nxt   = wstate;
    wbank_nxt    = wbank;
    widx_nxt     = widx;
    fc_nxt       = frame_count;
    ovf_nxt      = overflow;
    set_full     = 2'b00;
    ram_we_c     = 1'b0;
    ram_waddr_c  = {wbank, widx};
    other_free_c = !full[~wbank] || (rd_free_c && (rbank == ~wbank));
    unique case (wstate)
      W_FILL: begin
        if (conv_valid) begin
          ram_we_c = 1'b1;
          if (widx == LAST_IDX) begin
            set_full[wbank] = 1'b1;
            widx_nxt        = '0;
            if (other_free_c) begin
              wbank_nxt = ~wbank;
              fc_nxt    = frame_count + 16'd1;
            end else begin
              wstate_nxt = W_WAIT;
            end
          end else begin
            widx_nxt = widx + IDX_W'(1);
          end
        end
      end
      W_WAIT: begin
        if (other_free_c) begin
          wbank_nxt  = ~wbank;
          fc_nxt     = frame_count + 16'd1;
          wstate_nxt = W_FILL;
          if (conv_valid) begin
            ram_we_c    = 1'b1;
            ram_waddr_c = {~wbank, {IDX_W{1'b0}}};
            widx_nxt    = IDX_W'(1);
          end
        end else if (conv_valid) begin
          ovf_nxt = 1'b1;
        end
      end
    endcase
  end

  // Read side: claim the non-write full bank and prefetch while there is room
  always_comb begin
    rstate_nxt   = rstate;
    rbank_nxt    = rbank;
    fidx_nxt     = fidx;
    clr_full     = 2'b00;
    ram_re_c     = 1'b0;
    fetch_bank_c = rbank;
    fetch_idx_c  = fidx[IDX_W-1:0];
    unique case (rstate)
      R_IDLE: begin
        if (full[~wbank]) begin
          rbank_nxt    = ~wbank;
          rstate_nxt   = R_STREAM;
          ram_re_c     = 1'b1;
          fetch_bank_c = ~wbank;
          fetch_idx_c  = '0;
          fidx_nxt     = (IDX_W + 1)'(1);
        end
      end
      R_STREAM: begin
        if (!fidx[IDX_W] && (occ_c < 2'd2)) begin
          ram_re_c = 1'b1;
          fidx_nxt = fidx + (IDX_W + 1)'(1);
        end
        if (rd_free_c) begin
          clr_full[rbank] = 1'b1;
          rstate_nxt      = R_IDLE;
        end
      end
    endcase
    pend_first_nxt = ram_re_c && (fetch_idx_c == '0);
    pend_last_nxt  = ram_re_c && (fetch_idx_c == LAST_IDX);
  end

  // Output head plus one skid slot so a stall never loses an in-flight read
  always_comb begin
    head_nxt       = head;
    head_valid_nxt = head_valid;
    skid_nxt       = skid;
    skid_valid_nxt = skid_valid;
    ram_word_c     = '{data: ram_rdata, first: pend_first, last: pend_last};
    if (head_valid && !pop_c) begin
      if (rd_pend) begin
        skid_nxt       = ram_word_c;
        skid_valid_nxt = 1'b1;
      end
    end else if (skid_valid) begin
      head_nxt       = skid;
      head_valid_nxt = 1'b1;
      skid_valid_nxt = rd_pend;
      if (rd_pend) begin
        skid_nxt = ram_word_c;
      end
    end else if (rd_pend) begin
      head_nxt       = ram_word_c;
      head_valid_nxt = 1'b1;
    end else begin
      head_nxt       = '0;
      head_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge sampling_clk or negedge rst) begin
    if (!rst) begin
      wstate      <= W_FILL;
      wbank       <= 1'b0;
      widx        <= '0;
      full        <= 2'b00;
      frame_count <= '0;
      overflow    <= 1'b0;
      rstate      <= R_IDLE;
      rbank       <= 1'b0;
      fidx        <= '0;
      rd_pend     <= 1'b0;
      pend_first  <= 1'b0;
      pend_last   <= 1'b0;
      head        <= '0;
      head_valid  <= 1'b0;
      skid        <= '0;
      skid_valid  <= 1'b0;
    end else begin
      wstate      <= wstate_nxt;
      wbank       <= wbank_nxt;
      widx        <= widx_nxt;
      full        <= (full | set_full) & ~clr_full;
      frame_count <= fc_nxt;
      overflow    <= ovf_nxt;
      rstate      <= rstate_nxt;
      rbank       <= rbank_nxt;
      fidx        <= fidx_nxt;
      rd_pend     <= ram_re_c;
      pend_first  <= pend_first_nxt;
      pend_last   <= pend_last_nxt;
      head        <= head_nxt;
      head_valid  <= head_valid_nxt;
      skid        <= skid_nxt;
      skid_valid  <= skid_valid_nxt;
    end
  end

  assign out_data  = head.data;
  assign out_valid = head_valid;
  assign out_first = head.first;
  assign out_last  = head.last;

  frame_pingpong_ram #(.FRAME_LEN(FRAME_LEN)) u_ram (
    .sampling_clk (sampling_clk),
    .we           (ram_we_c),
    .waddr        (ram_waddr_c),
    .wdata        (conv_data),
    .re           (ram_re_c),
    .raddr        ({fetch_bank_c, fetch_idx_c}),
    .rdata        (ram_rdata)
  );

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer with FRAME_LEN=8: reset, conversion,
// backpressure, overflow and the fill/free swap race.
module tb_audio_frame_buffer;

  localparam int unsigned FL = 8;

  logic        sampling_clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_first;
  logic        out_last;
  logic        overflow;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got_data  [$];
  logic        got_first [$];
  logic        got_last  [$];
  int          got_cyc   [$];

  audio_frame_buffer #(.FRAME_LEN(FL)) dut (
    .sampling_clk (sampling_clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_first    (out_first),
    .out_last     (out_last),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  always #5 sampling_clk = ~sampling_clk;

  task automatic tick();
    @(posedge sampling_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; sample_valid = 1'b0; sample_in = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic drive(input logic [11:0] code);
    sample_in = {4'hA, code};
    sample_valid = 1'b1;
    tick();
  endtask

  task automatic send_seq(input int base, input int n);
    for (int i = 0; i < n; i++) drive(12'(base + i));
    sample_valid = 1'b0;
  endtask

  // Accept up to n words with out_ready=1, recording each transfer and its cycle
  task automatic collect(input int n, input int max_cyc);
    got_data.delete(); got_first.delete(); got_last.delete(); got_cyc.delete();
    out_ready = 1'b1;
    for (int c = 0; c < max_cyc && got_data.size() < n; c++) begin
      if (out_valid) begin
        got_data.push_back(out_data);
        got_first.push_back(out_first);
        got_last.push_back(out_last);
        got_cyc.push_back(c);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sample_valid = 1'b0; sample_in = '0; out_ready = 1'b0;
    #3;
    checks++;
    if ({out_valid, out_first, out_last, overflow, out_data, frame_count} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%h fc=%0d ovf=%b want all 0",
               out_valid, out_data, frame_count, overflow);
    end
    tick();
    rst = 1'b1;
    tick();
    send_seq(2048, 8);
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL prereset_valid got %b want 1", out_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_first, out_last, overflow, out_data, frame_count} !== 36'd0) begin
      failures++;
      $display("FAIL async_reset got valid=%b data=%h fc=%0d want all 0",
               out_valid, out_data, frame_count);
    end
    tick();
    rst = 1'b1;
    tick();
    send_seq(2048, 8);
    collect(8, 40);
    checks++;
    if (got_data.size() != 8) begin
      failures++;
      $display("FAIL reset_frame_len got %0d want 8", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 16'(8 * i) || got_first[i] !== (i == 0)) begin
        failures++;
        $display("FAIL reset_frame_word%0d got data=%0d first=%b want data=%0d first=%b",
                 i, $signed(got_data[i]), got_first[i], 8 * i, (i == 0));
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      failures++;
      $display("FAIL reset_frame_count got %0d want 1", frame_count);
    end
  endtask

  task automatic test_conversion();
    logic [11:0] codes [8] = '{12'd2048, 12'd4095, 12'd0, 12'd2049,
                               12'd2052, 12'd1024, 12'd3072, 12'd2040};
    logic [15:0] expv  [8] = '{16'd0, 16'd16376, 16'hC000, 16'd8,
                               16'd32, 16'hE000, 16'd8192, 16'hFFC0};
    do_reset();
    for (int i = 0; i < 8; i++) drive(codes[i]);
    sample_valid = 1'b0;
    collect(8, 40);
    checks++;
    if (got_data.size() != 8) begin
      failures++;
      $display("FAIL conv_count got %0d want 8", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== expv[i] || got_first[i] !== (i == 0) || got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL conv_word%0d got %0d f=%b l=%b want %0d f=%b l=%b", i,
                 $signed(got_data[i]), got_first[i], got_last[i],
                 $signed(expv[i]), (i == 0), (i == 7));
      end
    end
    if (got_cyc.size() == 8) begin
      checks++;
      if (got_cyc[0] > 4) begin
        failures++;
        $display("FAIL conv_first_latency got cycle %0d want <=4", got_cyc[0]);
      end
      checks++;
      if (got_cyc[7] - got_cyc[0] != 7) begin
        failures++;
        $display("FAIL conv_back_to_back got span %0d want 7", got_cyc[7] - got_cyc[0]);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      failures++;
      $display("FAIL conv_frame_count got %0d want 1", frame_count);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat = 4'b1001;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_first = 1'b0;
    logic        prev_last = 1'b0;
    int          cnt = 0;
    int          extra = 0;
    do_reset();
    send_seq(1000, 0);
    for (int i = 0; i < 8; i++) drive(12'(1000 + 300 * i));
    sample_valid = 1'b0;
    for (int c = 0; c < 80 && cnt < 8; c++) begin
      out_ready = pat[2'(c)];
      if (out_valid && prev_stall) begin
        checks++;
        if (out_data !== prev_data || out_first !== prev_first || out_last !== prev_last) begin
          failures++;
          $display("FAIL bp_hold got %h/%b/%b want %h/%b/%b", out_data, out_first, out_last,
                   prev_data, prev_first, prev_last);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_first = out_first;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 16'((1000 + 300 * cnt - 2048) * 8)) begin
          failures++;
          $display("FAIL bp_word%0d got %0d want %0d", cnt, $signed(out_data),
                   (1000 + 300 * cnt - 2048) * 8);
        end
        cnt++;
      end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) extra++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (cnt + extra != 8) begin
      failures++;
      $display("FAIL bp_transfers got %0d want 8", cnt + extra);
    end
    checks++;
    if (frame_count !== 16'd1) begin
      failures++;
      $display("FAIL bp_frame_count got %0d want 1", frame_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_seq(2048, 24);
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag got %b want 1", overflow);
    end
    collect(16, 120);
    checks++;
    if (got_data.size() != 16) begin
      failures++;
      $display("FAIL ovf_count got %0d want 16", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 16'(8 * i) || got_first[i] !== (i % 8 == 0) ||
          got_last[i] !== (i % 8 == 7)) begin
        failures++;
        $display("FAIL ovf_word%0d got %0d f=%b l=%b want %0d", i, $signed(got_data[i]),
                 got_first[i], got_last[i], 8 * i);
      end
    end
    collect(1, 10);
    checks++;
    if (got_data.size() != 0) begin
      failures++;
      $display("FAIL ovf_extra_frame got %0d words want 0", got_data.size());
    end
    checks++;
    if (frame_count !== 16'd2 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_final got fc=%0d ovf=%b want fc=2 ovf=1", frame_count, overflow);
    end
  endtask

  task automatic test_swap_race();
    int popped = 0;
    do_reset();
    send_seq(2048, 8);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && popped < 7; c++) begin
      if (out_valid) popped++;
      tick();
    end
    out_ready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 16'd56) begin
      failures++;
      $display("FAIL race_head got v=%b l=%b d=%0d want v=1 l=1 d=56", out_valid, out_last,
               $signed(out_data));
    end
    for (int i = 0; i < 8; i++) drive(12'(2056 + i));
    // last sample of frame B converts now while the reader frees frame A
    sample_in = {4'h0, 12'd2200};
    sample_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    sample_valid = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (overflow !== 1'b0 || frame_count !== 16'd2) begin
      failures++;
      $display("FAIL race_swap got ovf=%b fc=%0d want ovf=0 fc=2", overflow, frame_count);
    end
    collect(8, 40);
    checks++;
    if (got_data.size() != 8) begin
      failures++;
      $display("FAIL race_count got %0d want 8", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 16'(64 + 8 * i)) begin
        failures++;
        $display("FAIL race_word%0d got %0d want %0d", i, $signed(got_data[i]), 64 + 8 * i);
      end
    end
    collect(1, 10);
    checks++;
    if (got_data.size() != 0) begin
      failures++;
      $display("FAIL race_partial got %0d words want 0", got_data.size());
    end
  endtask

`ifdef AUDIO_FRAME_DC_BLOCK_EN
  task automatic test_dc_block();
    logic [15:0] last_v = 16'h7FFF;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      sample_in = {4'h0, 12'd3000};
      sample_valid = 1'b1;
      if (out_valid) last_v = out_data;
      tick();
    end
    sample_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) last_v = out_data;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if ($signed(last_v) >= 64 || $signed(last_v) <= -64) begin
      failures++;
      $display("FAIL dc_residual got %0d want |x|<64", $signed(last_v));
    end
  endtask
`endif

  initial begin
    rst = 1'b0; sample_valid = 1'b0; sample_in = '0; out_ready = 1'b0;
    test_reset();
`ifdef AUDIO_FRAME_DC_BLOCK_EN
    test_dc_block();
`else
    test_conversion();
    test_backpressure();
    test_overflow();
    test_swap_race();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_frame_buffer.md
Name: audio_frame_buffer

Overview:
- Downstream of the microphone sampling stage: consumes the 16-bit `time_domain` sample word (12-bit unsigned ADC code in bits [11:0]).
- Converts each sample to signed, offset-removed Q1.15 and packs FRAME_LEN consecutive samples into frames in a ping-pong buffer.
- Streams each complete frame to the spectrum (FFT) stage over a valid/ready interface, with first/last markers.

Parameters:
- FRAME_LEN, 256: samples per frame; power of two, 8..1024.
- ADC_MID, 2048: unsigned ADC code treated as zero signal.
- DCB_SHIFT, 8: IIR time-constant shift; used only with the optional feature.

Ports:
- sampling_clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_in  in  16  raw sample word; bits [15:12] ignored.
- sample_valid  in  1  sample_in holds a new sample this cycle.
- out_data  out  16  signed Q1.15 sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word this cycle.
- out_first  out  1  out_data is sample 0 of its frame.
- out_last  out  1  out_data is sample FRAME_LEN-1 of its frame.
- overflow  out  1  sticky; set when a sample was dropped.
- frame_count  out  16  complete frames handed to the read side; wraps at 2^16.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Write bank=0, write index=0, both banks empty.
  - Read FSM in R_IDLE; DC accumulator = ADC_MID<<DCB_SHIFT.
- Conversion, one pipeline register, 1-cycle latency from sample_valid:
  - d = sample_in[11:0] − ADC_MID, 13-bit signed.
  - q = d<<3, saturated to [−32768, 32767].
  - Code 0 maps to −16384; code 4095 maps to 16376.
- Write side FSM:
  - W_FILL: each converted sample is written at [wbank][widx] and widx increments. At widx=FRAME_LEN−1 the bank is marked full and widx wraps to 0.
    - If the other bank is empty: wbank toggles, frame_count increments, and the FSM stays in W_FILL.
    - Otherwise: go to W_WAIT.
  - W_WAIT: incoming samples are dropped and overflow is set (sticky until reset).
    - When the read side frees the other bank: toggle wbank, increment frame_count, return to W_FILL.
    - If a sample arrives in that same cycle, it is written at index 0 of the new bank, not dropped.
- Read side FSM:
  - R_IDLE: when a full bank is present that is not the current write bank, latch rbank and ridx=0, go to R_STREAM.
  - R_STREAM: buffer RAM has a 1-cycle synchronous read. A prefetch register plus a 1-entry skid is used so out_valid stays high back-to-back while out_ready=1.
    - out_first=(ridx==0); out_last=(ridx==FRAME_LEN−1).
    - Transfer happens only when out_valid && out_ready.
    - out_data, out_first and out_last are held stable while out_valid=1 and out_ready=0.
    - After the last transfer the bank is marked empty, in the same cycle as the transfer. The FSM then returns to R_IDLE.
  - First word of a frame: out_valid rises ≤3 cycles after the bank becomes full.
- Simultaneous events: the write bank becoming full and the read bank being freed in the same cycle resolves to an immediate swap, with no W_WAIT entry and no drop.
- Boundary conditions:
  - A frame is never emitted partially.
  - Frames are emitted strictly in capture order.
  - A dropped sample is never written into any frame.
- Reset mid-frame: the partial frame and any streaming frame are discarded; the interface restarts clean.
- Throughput: sustains sample_valid=1 every cycle when out_ready=1 continuously.

Optional Feature:
- Macro AUDIO_FRAME_DC_BLOCK_EN.
- Defined: ADC_MID is replaced by a tracked mean.
  - acc += x − (acc>>>DCB_SHIFT) on each valid sample, where acc is a (12+DCB_SHIFT)-bit unsigned register.
  - d = x − (acc>>DCB_SHIFT).
  - Conversion latency becomes 2 cycles.
- Undefined: the fixed ADC_MID subtraction as described above; no accumulator is synthesized.

Decomposition:
- Package audio_pkg:
  - typedef sample_t (logic signed [15:0]).
  - typedef adc_code_t (logic [11:0]).
  - enum wr_state_t {W_FILL, W_WAIT}.
  - enum rd_state_t {R_IDLE, R_STREAM}.
  - Constant ADC_BITS=12.
- One sub-module, frame_pingpong_ram: 2×FRAME_LEN×16 simple dual-port RAM with 1-cycle registered read, so it infers block RAM.

Test Plan (FRAME_LEN=8):
- Reset behaviour: assert rst=0 mid-stream → all outputs 0 immediately. After release, 8 valid samples → one frame, out_first on word 0.
- Conversion: codes 2048, 4095, 0, 2049 with out_ready=1 → out_data 0, 16376, −16384, 8 in order; out_last on the 8th word; frame_count=1.
- Backpressure: out_ready toggled 1,0,0,1 during a frame → out_data held stable while stalled, no word lost or duplicated, exactly 8 transfers.
- Overflow: out_ready=0, 24 valid samples → two frames captured (samples 0–15), samples 16–23 dropped, overflow=1, frame_count=2. Then out_ready=1 → words 0..15 emitted in order.
- Swap race: read bank freed on the same cycle the write bank fills, with a sample arriving next cycle → no drop, overflow stays 0.
- With AUDIO_FRAME_DC_BLOCK_EN: constant code 3000 for 4096 samples → |out_data| < 64 by the end.
